// File: rtl/smm_cif_udiv_pkg.sv
// Shared types and constants for the sequential unsigned divider.
package smm_cif_udiv_pkg;

   localparam int SMM_CIF_UDIV_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/smm_cif_udiv_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, and shift the outcome
// bit into the quotient.
module smm_cif_udiv_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] q,
   input  logic [W-1:0] d,
   output logic [W-1:0] a_nxt,
   output logic [W-1:0] q_nxt
);

   logic [W:0] t;

   // Trial subtraction on the (W+1)-bit shifted remainder. When it fits, the
   // difference is below d, so the low W bits are the exact new remainder.
   always_comb begin
      t = {a, q[W-1]};
      if (t >= {1'b0, d}) begin
         a_nxt = t[W-1:0] - d;
         q_nxt = {q[W-2:0], 1'b1};
      end else begin
         a_nxt = t[W-1:0];
         q_nxt = {q[W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/smm_cif_udiv_seq.sv
// Sequential unsigned divider, one quotient bit per enabled cycle, with a
// start/done handshake and a global ce stall.
// Optional build macro SMM_CIF_UDIV_ZERO_BYPASS_EN: a zero divisor skips the
// W iterations and completes one cycle after acceptance. Results are the
// same either way; only the timing differs.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// BUSY  | iterating, cnt counts remaining steps down to 0
// DONE  | result valid, done=1; start here issues back-to-back
module smm_cif_udiv_seq
   import smm_cif_udiv_pkg::*;
#(
   parameter int W = SMM_CIF_UDIV_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ce,
   input  logic         start,
   input  logic [W-1:0] din0,
   input  logic [W-1:0] din1,
   output logic         ready,
   output logic         done,
   output logic [W-1:0] quot,
   output logic [W-1:0] rem,
   output logic         div_by_zero
);

   localparam int CNT_W = $clog2(W + 1);

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [W-1:0]       a_r;
   logic [W-1:0]       q_r;
   logic [W-1:0]       d_r;
   logic [W-1:0]       a_nxt;
   logic [W-1:0]       q_nxt;
   logic               accept;
   logic               zero_byp;
   logic               last_step;

   assign accept    = ce && start && (state != BUSY);
   assign last_step = (state == BUSY) && (cnt == CNT_W'(1));

`ifdef SMM_CIF_UDIV_ZERO_BYPASS_EN
   assign zero_byp = accept && (din1 == '0);
`else
   assign zero_byp = 1'b0;
`endif

   smm_cif_udiv_step #(.W(W)) u_step (
      .a     (a_r),
      .q     (q_r),
      .d     (d_r),
      .a_nxt (a_nxt),
      .q_nxt (q_nxt)
   );

   // State register; reset wins over ce.
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; nothing advances while ce is low.
   always_comb begin
      state_nxt = state;
      if (ce) begin
         case (state)
            IDLE:    if (start) state_nxt = zero_byp ? DONE : BUSY;
            BUSY:    if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = start ? (zero_byp ? DONE : BUSY) : IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Handshake outputs decoded from the state register only.
   always_comb begin
      ready = (state != BUSY);
      done  = (state == DONE);
   end

   // Operand load, per-step update, and result capture on the final step.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt         <= '0;
         a_r         <= '0;
         q_r         <= '0;
         d_r         <= '0;
         quot        <= '0;
         rem         <= '0;
         div_by_zero <= 1'b0;
      end else if (ce) begin
         if (accept) begin
            if (zero_byp) begin
               cnt         <= '0;
               quot        <= '1;
               rem         <= din0;
               div_by_zero <= 1'b1;
            end else begin
               cnt <= CNT_W'(W);
               a_r <= '0;
               q_r <= din0;
               d_r <= din1;
            end
         end else if (state == BUSY) begin
            cnt <= cnt - CNT_W'(1);
            a_r <= a_nxt;
            q_r <= q_nxt;
            if (last_step) begin
               quot        <= q_nxt;
               rem         <= a_nxt;
               div_by_zero <= (d_r == '0);
            end
         end
      end
   end

endmodule

// File: doc/smm_cif_udiv_seq.md
Name: smm_cif_udiv_seq

Overview:
Sequential unsigned integer divider. It is the inverse arithmetic companion to the pipelined 32x32 unsigned multiplier used in the SMM_CIF datapath. It computes quotient and remainder with a radix-2 restoring algorithm, one bit per enabled cycle. Index and address-recovery logic uses it under a start/done handshake, gated by the same ce stall signal as the multiplier.

Parameters:
- W, 32: dividend, divisor, quotient and remainder width in bits; legal range 2..64.
- CNT_W, $clog2(W+1): step counter width; derived, never overridden.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-low reset.
- ce, input, 1: clock enable; when low, all registers hold.
- start, input, 1: request; sampled only when ce=1 and ready=1.
- din0, input, W: dividend, unsigned; sampled with start.
- din1, input, W: divisor, unsigned; sampled with start.
- ready, output, 1: high in IDLE or DONE; a new start is accepted.
- done, output, 1: high exactly while in DONE.
- quot, output, W: quotient; valid while done=1; holds until the next accepted start.
- rem, output, W: remainder; same validity as quot.
- div_by_zero, output, 1: divisor was 0; same validity as quot.

Behaviour:
- Reset (reset=0 at a clk edge, regardless of ce):
  - state returns to IDLE.
  - quot, rem, div_by_zero and done all go to 0; ready goes to 1.
  - counter and working registers are cleared.
  - Reset mid-operation aborts the division; no done pulse follows.
- States: IDLE, BUSY, DONE (2-bit enum).
  - IDLE to BUSY on edge E0 with ce=1 and start=1. Loads A=0, Q=din0, D=din1, cnt=W.
  - BUSY, per ce=1 edge:
    - Compute T=(A<<1)|Q[W-1], a (W+1)-bit subtraction.
    - If T>=D: A=T-D, Q=(Q<<1)|1.
    - Otherwise: A=T, Q=Q<<1.
    - cnt decrements by 1.
  - BUSY to DONE on the edge where cnt goes 1 to 0, i.e. edge E_W. On that edge quot=Q and rem=A are registered; div_by_zero=(D==0).
  - DONE to IDLE on the next ce=1 edge if start=0.
  - DONE to BUSY if start=1 (back-to-back; loads new operands that same edge).
- Latency: done is high in the cycle after the W-th enabled edge following acceptance. For W=32 that is 33 enabled edges from acceptance to the done-to-IDLE transition.
- Throughput: one result per W+1 enabled cycles. Back-to-back issue sustains this.
- ce=0 freezes state, counter and outputs, including done. A stalled DONE holds done high until a ce=1 edge.
- start while BUSY is ignored and has no side effects.
- Divisor 0 (restoring result, no special path): quot=all-ones, rem=din0, div_by_zero=1.
- din0 < din1: quot=0, rem=din0.
- Outputs are registers only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SMM_CIF_UDIV_ZERO_BYPASS_EN.
- Defined:
  - IDLE/DONE with start and din1==0 goes directly to DONE on E0.
  - quot=all-ones, rem=din0, div_by_zero=1 are registered on that edge.
  - done is high in the next cycle (latency 1).
- Undefined: divide-by-zero runs the full W steps; results are bit-identical to the defined case, only timing differs.

Decomposition:
- Package smm_cif_udiv_pkg holds:
  - the state enum (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the default width constant SMM_CIF_UDIV_W=32.
- Sub-module smm_cif_udiv_step: purely combinational, parameterised by W. Inputs A, Q, D; outputs next A and next Q. Instantiated once; the top holds the FSM, counter and registers.

Test Plan:
- W=32, din0=100, din1=7, ce=1: done exactly at cycle E0+33; quot=14, rem=2, div_by_zero=0, ready=1.
- din0=0xFFFFFFFF, din1=1: quot=0xFFFFFFFF, rem=0. Then din0=0xFFFFFFFF, din1=0xFFFFFFFF: quot=1, rem=0. Then din0=5, din1=9: quot=0, rem=5.
- din0=5, din1=0:
  - both builds give quot=0xFFFFFFFF, rem=5, div_by_zero=1;
  - with the macro, done at E0+1; without, done at E0+33.
- ce toggling 1,0 every cycle during 100/7: same results; done after exactly 32 enabled step edges. Outputs frozen while ce=0. start pulsed while BUSY has no effect.
- reset=0 at step 10 of 1000/3: next cycle quot=0, rem=0, done=0, ready=1, state IDLE, no late done. A fresh 1000/3 then yields quot=333, rem=1.
- Back-to-back: start held high with 1000/3 then 77/8:
  - second operation accepted on the DONE-cycle edge;
  - results 333/1, then 9/5;
  - done pulses spaced exactly 33 cycles apart.
